// File: rtl/n64_pkg.sv
// Shared Joybus definitions: EEPROM mode encoding, command bytes, info ID bytes.
// Pure declarations, no logic.
// Imported by the SI EEPROM responder.
package n64_pkg;

   typedef enum logic [1:0] {
      EEPROM_OFF   = 2'd0,
      EEPROM_4K    = 2'd1,
      EEPROM_16K   = 2'd2,
      EEPROM_OFF_3 = 2'd3
   } e_eeprom_mode;

   // Kind of response being built once the frame has been decoded
   typedef enum logic [1:0] {
      RESP_INFO  = 2'd0,
      RESP_READ  = 2'd1,
      RESP_WRITE = 2'd2
   } e_resp_kind;

   localparam logic [7:0] CMD_INFO         = 8'h00;
   localparam logic [7:0] CMD_RESET        = 8'hFF;
   localparam logic [7:0] CMD_EEPROM_READ  = 8'h04;
   localparam logic [7:0] CMD_EEPROM_WRITE = 8'h05;

   localparam logic [7:0] INFO_ID_4K  = 8'h80;
   localparam logic [7:0] INFO_ID_16K = 8'hC0;

endpackage

// File: rtl/n64_si_eeprom.sv
// Joybus EEPROM responder: decodes info/read/write frames from the SI PHY and answers them.
// Latency: rx_ready to tx_start is 9 cycles worst case with zero-wait memory.
// Backpressure: mem_req is held until mem_ack; the response waits for tx_busy to drop.
module n64_si_eeprom
   import n64_pkg::*;
#(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        eeprom_mode,
   output logic              rx_reset,
   input  logic              rx_ready,
   input  logic [6:0]        rx_length,
   input  logic [80:0]       rx_data,
   output logic              tx_reset,
   output logic              tx_start,
   input  logic              tx_busy,
   output logic [2:0]        tx_wmask,
   output logic [6:0]        tx_length,
   output logic [31:0]       tx_data,
   output logic              mem_req,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ack
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_MEM_READ,
      S_MEM_WRITE,
      S_TX_LOAD,
      S_TX_START,
      S_TX_WAIT,
      S_DROP
   } e_state;

   e_state       state;
   e_resp_kind   kind;
   e_eeprom_mode mode;
   logic [7:0]   block;
   logic [7:0]   info_id;
   logic [31:0]  word0;
   logic [31:0]  word1;
   logic         word_idx;
   logic [1:0]   load_idx;
   logic         first_wait;
   logic [3:0]   n_bytes;
   logic [7:0]   cmd;
   logic [7:0]   addr_byte;
   logic         mode_on;

   // Byte k of an n-byte frame lives at data[8(n-k) : 8(n-k)-7]; out-of-range bytes read as 0
   function automatic logic [7:0] frame_byte(input logic [80:0] data, input logic [3:0] n, input int k);
      logic [87:0] ext;
      int          pos;
      ext = {data, 7'b0};
      pos = 8 * (int'(n) - k);
      if (pos < 0 || pos > 80) begin
         return 8'h00;
      end
      ext = ext >> pos;
      return ext[7:0];
   endfunction

   assign tx_reset  = 1'b0;
   assign mode      = e_eeprom_mode'(eeprom_mode);
   assign mode_on   = (mode == EEPROM_4K) || (mode == EEPROM_16K);
   assign n_bytes   = rx_length[6:3];
   assign cmd       = frame_byte(rx_data, n_bytes, 0);
   assign addr_byte = frame_byte(rx_data, n_bytes, 1);

   // Main controller: decode, two memory word accesses, response load, transmit handshake
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         kind        <= RESP_INFO;
         block       <= 8'h00;
         info_id     <= 8'h00;
         word0       <= 32'h0;
         word1       <= 32'h0;
         word_idx    <= 1'b0;
         load_idx    <= 2'd0;
         first_wait  <= 1'b0;
         rx_reset    <= 1'b0;
         tx_start    <= 1'b0;
         tx_wmask    <= 3'b000;
         tx_length   <= 7'd0;
         tx_data     <= 32'h0;
         mem_req     <= 1'b0;
         mem_write   <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= 32'h0;
      end else begin
         rx_reset <= 1'b0;
         tx_start <= 1'b0;
         tx_wmask <= 3'b000;
         case (state)
            S_IDLE: begin
               if (rx_ready) state <= S_DECODE;
            end
            S_DECODE: begin
               // Everything needed later is captured here, before tx_wmask overwrites the shared register
               block    <= (mode == EEPROM_4K) ? {2'b00, addr_byte[5:0]} : addr_byte;
               info_id  <= (mode == EEPROM_4K) ? INFO_ID_4K : INFO_ID_16K;
               word0    <= {frame_byte(rx_data, n_bytes, 2), frame_byte(rx_data, n_bytes, 3),
                            frame_byte(rx_data, n_bytes, 4), frame_byte(rx_data, n_bytes, 5)};
               word1    <= {frame_byte(rx_data, n_bytes, 6), frame_byte(rx_data, n_bytes, 7),
                            frame_byte(rx_data, n_bytes, 8), frame_byte(rx_data, n_bytes, 9)};
               word_idx <= 1'b0;
               load_idx <= 2'd0;
               if (!mode_on || rx_length[2:0] != 3'd1) begin
                  state <= S_DROP;
               end else if ((cmd == CMD_INFO || cmd == CMD_RESET) && n_bytes == 4'd1) begin
                  kind  <= RESP_INFO;
                  state <= S_TX_LOAD;
               end else if (cmd == CMD_EEPROM_READ && n_bytes == 4'd2) begin
                  kind  <= RESP_READ;
                  state <= S_MEM_READ;
               end else if (cmd == CMD_EEPROM_WRITE && n_bytes == 4'd10) begin
                  kind  <= RESP_WRITE;
                  state <= S_MEM_WRITE;
               end else begin
                  state <= S_DROP;
               end
            end
            S_MEM_READ, S_MEM_WRITE: begin
               // A low mem_req means the next word has not been requested yet
               if (!mem_req) begin
                  mem_req     <= 1'b1;
                  mem_write   <= (state == S_MEM_WRITE);
                  mem_address <= ADDR_W'({block, word_idx});
                  mem_wdata   <= word_idx ? word1 : word0;
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (state == S_MEM_READ) begin
                     if (word_idx) word1 <= mem_rdata;
                     else          word0 <= mem_rdata;
                  end
                  if (word_idx) state    <= S_TX_LOAD;
                  else          word_idx <= 1'b1;
               end
            end
            S_TX_LOAD: begin
               case (load_idx)
                  2'd0: begin
                     tx_wmask <= 3'b001;
                     case (kind)
                        RESP_INFO: begin
                           tx_data   <= {8'h00, info_id, 8'h00, 8'h80};
                           tx_length <= 7'd25;
                        end
                        RESP_WRITE: begin
                           tx_data   <= 32'h0080_0000;
                           tx_length <= 7'd9;
                        end
                        default: begin
                           tx_data   <= word0;
                           tx_length <= 7'd65;
                        end
                     endcase
                  end
                  2'd1: begin
                     tx_wmask <= 3'b010;
                     tx_data  <= word1;
                  end
                  default: begin
                     tx_wmask <= 3'b100;
                     tx_data  <= 32'h0001_0000;
                  end
               endcase
               if (kind != RESP_READ || load_idx == 2'd2) state    <= S_TX_START;
               else                                       load_idx <= load_idx + 2'd1;
            end
            S_TX_START: begin
               tx_start   <= 1'b1;
               first_wait <= 1'b1;
               state      <= S_TX_WAIT;
            end
            S_TX_WAIT: begin
               // The PHY reports busy one cycle after tx_start, so the first cycle is skipped
               if (first_wait) begin
                  first_wait <= 1'b0;
               end else if (!tx_busy) begin
                  rx_reset <= 1'b1;
                  state    <= S_IDLE;
               end
            end
            default: begin
               rx_reset <= 1'b1;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_n64_si_eeprom.sv
// Directed bench for the Joybus EEPROM responder with PHY busy and memory models.
// Outputs sampled on the falling edge; memory ack arrives one cycle after request.
// Reset-abandon case holds the memory ack off to catch a pending request.
module tb_n64_si_eeprom;

   logic        clk;
   logic        reset;
   logic [1:0]  eeprom_mode;
   logic        rx_reset;
   logic        rx_ready;
   logic [6:0]  rx_length;
   logic [80:0] rx_data;
   logic        tx_reset;
   logic        tx_start;
   logic        tx_busy;
   logic [2:0]  tx_wmask;
   logic [6:0]  tx_length;
   logic [31:0] tx_data;
   logic        mem_req;
   logic        mem_write;
   logic [8:0]  mem_address;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int tests = 0;
   int fails = 0;

   // Observations gathered by the falling-edge monitor
   int          start_cnt;
   int          rst_cnt;
   int          req_cycles;
   int          busy_cnt;
   logic        busy_seen;
   logic        busy_at_rst;
   logic [6:0]  len_at_start;
   logic [2:0]  mask_acc;
   logic [31:0] tx_word [3];
   int          mem_n;
   logic [8:0]  log_addr [4];
   logic        log_wr [4];
   logic [31:0] log_dat [4];
   logic [31:0] mem [512];
   logic        mem_hold;

   n64_si_eeprom #(.ADDR_W(9)) dut (
      .clk(clk), .reset(reset), .eeprom_mode(eeprom_mode),
      .rx_reset(rx_reset), .rx_ready(rx_ready), .rx_length(rx_length), .rx_data(rx_data),
      .tx_reset(tx_reset), .tx_start(tx_start), .tx_busy(tx_busy), .tx_wmask(tx_wmask),
      .tx_length(tx_length), .tx_data(tx_data),
      .mem_req(mem_req), .mem_write(mem_write), .mem_address(mem_address),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PHY busy model, memory responder and output monitor
   always @(negedge clk) begin
      if (tx_start) begin
         start_cnt++;
         len_at_start = tx_length;
         tx_busy   = 1'b1;
         busy_seen = 1'b1;
         busy_cnt  = 4;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (rx_reset) begin
         rst_cnt++;
         busy_at_rst = tx_busy;
      end
      for (int i = 0; i < 3; i++) begin
         if (tx_wmask[i]) tx_word[i] = tx_data;
      end
      mask_acc = mask_acc | tx_wmask;
      if (mem_req) req_cycles++;
      if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (mem_req && !mem_hold) begin
         if (mem_n < 4) begin
            log_addr[mem_n] = mem_address;
            log_wr[mem_n]   = mem_write;
            log_dat[mem_n]  = mem_write ? mem_wdata : mem[mem_address];
         end
         mem_n++;
         if (mem_write) mem[mem_address] = mem_wdata;
         else           mem_rdata = mem[mem_address];
         mem_ack = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      start_cnt = 0; rst_cnt = 0; req_cycles = 0; mem_n = 0;
      busy_seen = 1'b0; busy_at_rst = 1'bx; len_at_start = 7'd0; mask_acc = 3'b000;
      for (int i = 0; i < 3; i++) tx_word[i] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         log_addr[i] = 9'h0; log_wr[i] = 1'b0; log_dat[i] = 32'h0;
      end
   endtask

   // Bytes packed with byte 0 in [79:72]; placed so byte k sits at [8(nb-k) : 8(nb-k)-7]
   task automatic send_frame(input logic [1:0] mode, input logic [6:0] len,
                             input logic [79:0] bytes, input int nb);
      logic [80:0] d;
      d = {1'b0, bytes} >> (8 * (10 - nb));
      d = d << 1;
      d[0] = 1'b1;
      @(negedge clk);
      clear_logs();
      eeprom_mode = mode;
      rx_length   = len;
      rx_data     = d;
      rx_ready    = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 100 && rst_cnt == 0; i++) @(negedge clk);
      chk(tag, 32'(rst_cnt > 0), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; eeprom_mode = 2'd0; rx_ready = 1'b0; rx_length = 7'd0; rx_data = '0;
      tx_busy = 1'b0; mem_rdata = 32'h0; mem_ack = 1'b0; mem_hold = 1'b0; busy_cnt = 0;
      for (int i = 0; i < 512; i++) mem[i] = 32'h0;
      mem[10] = 32'h1122_3344;
      mem[11] = 32'h5566_7788;
      clear_logs();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      chk("rst_tx_start", 32'(tx_start), 32'd0);
      chk("rst_rx_reset", 32'(rx_reset), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_tx_wmask", 32'(tx_wmask), 32'd0);
      chk("rst_tx_length", 32'(tx_length), 32'd0);
      chk("rst_tx_reset", 32'(tx_reset), 32'd0);

      // Info, 4 Kbit
      send_frame(2'd1, 7'd9, {8'h00, 72'h0}, 1);
      wait_done("info4k_done");
      chk("info4k_word0", tx_word[0], 32'h0080_0080);
      chk("info4k_mask", 32'(mask_acc), 32'b001);
      chk("info4k_len", 32'(len_at_start), 32'd25);
      chk("info4k_starts", 32'(start_cnt), 32'd1);
      chk("info4k_rsts", 32'(rst_cnt), 32'd1);
      chk("info4k_busy_seen", 32'(busy_seen), 32'd1);
      chk("info4k_rst_after_busy", 32'(busy_at_rst), 32'd0);
      chk("info4k_no_mem", 32'(req_cycles), 32'd0);

      // Reset command, 16 Kbit
      send_frame(2'd2, 7'd9, {8'hFF, 72'h0}, 1);
      wait_done("info16k_done");
      chk("info16k_word0", tx_word[0], 32'h00C0_0080);
      chk("info16k_starts", 32'(start_cnt), 32'd1);

      // Read, 4 Kbit, address 0x45 -> block 5 -> words 10, 11
      send_frame(2'd1, 7'd17, {8'h04, 8'h45, 64'h0}, 2);
      wait_done("read_done");
      chk("read_n", 32'(mem_n), 32'd2);
      chk("read_addr0", 32'(log_addr[0]), 32'd10);
      chk("read_addr1", 32'(log_addr[1]), 32'd11);
      chk("read_wr0", 32'(log_wr[0]), 32'd0);
      chk("read_wr1", 32'(log_wr[1]), 32'd0);
      chk("read_word0", tx_word[0], 32'h1122_3344);
      chk("read_word1", tx_word[1], 32'h5566_7788);
      chk("read_word2", tx_word[2], 32'h0001_0000);
      chk("read_mask", 32'(mask_acc), 32'b111);
      chk("read_len", 32'(len_at_start), 32'd65);
      chk("read_starts", 32'(start_cnt), 32'd1);

      // Write, 16 Kbit, address 0xFF -> words 510, 511
      send_frame(2'd2, 7'd81, {8'h05, 8'hFF, 64'h0102_0304_0506_0708}, 10);
      wait_done("write_done");
      chk("write_n", 32'(mem_n), 32'd2);
      chk("write_addr0", 32'(log_addr[0]), 32'd510);
      chk("write_addr1", 32'(log_addr[1]), 32'd511);
      chk("write_wr0", 32'(log_wr[0]), 32'd1);
      chk("write_dat0", log_dat[0], 32'h0102_0304);
      chk("write_dat1", log_dat[1], 32'h0506_0708);
      chk("write_mem510", mem[510], 32'h0102_0304);
      chk("write_mem511", mem[511], 32'h0506_0708);
      chk("write_word0", tx_word[0], 32'h0080_0000);
      chk("write_mask", 32'(mask_acc), 32'b001);
      chk("write_len", 32'(len_at_start), 32'd9);

      // Disabled mode drops a valid info frame
      send_frame(2'd0, 7'd9, {8'h00, 72'h0}, 1);
      wait_done("off_done");
      chk("off_starts", 32'(start_cnt), 32'd0);
      chk("off_mem", 32'(req_cycles), 32'd0);
      chk("off_rsts", 32'(rst_cnt), 32'd1);

      // Length not 8N+1 is dropped
      send_frame(2'd1, 7'd12, {8'h00, 72'h0}, 1);
      wait_done("badlen_done");
      chk("badlen_starts", 32'(start_cnt), 32'd0);
      chk("badlen_mem", 32'(req_cycles), 32'd0);
      chk("badlen_rsts", 32'(rst_cnt), 32'd1);

      // Reset while a read request is pending
      mem_hold = 1'b1;
      send_frame(2'd1, 7'd17, {8'h04, 8'h45, 64'h0}, 2);
      for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
      chk("abort_req_seen", 32'(mem_req), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_req_dropped", 32'(mem_req), 32'd0);
      reset = 1'b0;
      mem_hold = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_no_start", 32'(start_cnt), 32'd0);
      chk("abort_no_rst", 32'(rst_cnt), 32'd0);
      chk("abort_req_idle", 32'(mem_req), 32'd0);

      // Next info frame answered normally
      send_frame(2'd1, 7'd9, {8'h00, 72'h0}, 1);
      wait_done("post_done");
      chk("post_word0", tx_word[0], 32'h0080_0080);
      chk("post_starts", 32'(start_cnt), 32'd1);
      chk("post_len", 32'(len_at_start), 32'd25);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
